// File: rtl/note_pkg.sv
// Constants shared by the note generator and note detector: FSM encoding
// and the half-period limit that fixes the 8-bit period width.
package note_pkg;

    localparam int MAX_H    = 256;
    localparam int PERIOD_W = 8;
    localparam int CNT_W    = 9;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2,
        ST_LOST = 2'd3
    } state_t;

endpackage

// File: rtl/note_interval_counter.sv
// Registers the note input, flags level changes and counts the length of
// the current level, saturating at MAX_H.
module note_interval_counter #(
    parameter int MAX_H = note_pkg::MAX_H
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       note,
    output logic                       note_edge,
    output logic [note_pkg::CNT_W-1:0] h,
    output logic                       sat
);
    import note_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_H);

    logic             note_q;
    logic [CNT_W-1:0] cnt;

    // The edge cycle is the first cycle of the new level, so the count restarts at 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            note_q <= 1'b0;
            cnt    <= '0;
        end else begin
            note_q <= note;
            if (note_edge) begin
                cnt <= CNT_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign note_edge = (note != note_q);
    assign h         = cnt;
    assign sat       = (cnt == CNT_MAX);

endmodule

// File: rtl/note_detector.sv
// Receive end of the note interface: measures the half-period of a square
// wave, locks when two consecutive half-periods agree, and flags loss of signal.
module note_detector #(
    parameter int MAX_H = note_pkg::MAX_H
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          note,
    output logic [note_pkg::PERIOD_W-1:0] period,
    output logic                          valid,
    output logic [1:0]                    state,
    output logic                          locked
);
    import note_pkg::*;

    state_t              cur;
    state_t              nxt;
    logic [CNT_W-1:0]    cand;
    logic [CNT_W-1:0]    cand_nxt;
    logic                cand_v;
    logic                cand_v_nxt;
    logic [PERIOD_W-1:0] period_nxt;
    logic                valid_nxt;

    logic                note_edge;
    logic [CNT_W-1:0]    h;
    logic                sat;

    note_interval_counter #(
        .MAX_H(MAX_H)
    ) u_counter (
        .clk      (clk),
        .rst      (rst),
        .note     (note),
        .note_edge(note_edge),
        .h        (h),
        .sat      (sat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur    <= ST_WAIT;
            cand   <= '0;
            cand_v <= 1'b0;
            period <= '0;
            valid  <= 1'b0;
        end else begin
            cur    <= nxt;
            cand   <= cand_nxt;
            cand_v <= cand_v_nxt;
            period <= period_nxt;
            valid  <= valid_nxt;
        end
    end

    always_comb begin
        nxt        = cur;
        cand_nxt   = cand;
        cand_v_nxt = cand_v;
        period_nxt = period;
        valid_nxt  = 1'b0;

        // An edge takes priority over the timeout, so a full MAX_H level still measures.
        if (note_edge) begin
            case (cur)
                ST_WAIT, ST_LOST: begin
                    nxt        = ST_ACQ;
                    cand_v_nxt = 1'b0;
                end
                ST_ACQ: begin
                    if (cand_v && (h == cand)) begin
                        nxt        = ST_LOCK;
                        period_nxt = PERIOD_W'(h - 1'b1);
                        valid_nxt  = 1'b1;
                    end else begin
                        cand_nxt   = h;
                        cand_v_nxt = 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (h == cand) begin
                        period_nxt = PERIOD_W'(h - 1'b1);
                        valid_nxt  = 1'b1;
                    end else begin
                        nxt        = ST_ACQ;
                        cand_nxt   = h;
                        cand_v_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (sat && ((cur == ST_ACQ) || (cur == ST_LOCK))) begin
            nxt        = ST_LOST;
            cand_v_nxt = 1'b0;
        end
    end

    assign state  = cur;
    assign locked = (cur == ST_LOCK);

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector: directed level sequences, a timestamp-based model
// checked every cycle, and literal spot checks at phase boundaries.
module tb_note_detector;

    localparam int MAX_H = 256;

    logic       clk;
    logic       rst;
    logic       note;
    logic [7:0] period;
    logic       valid;
    logic [1:0] state;
    logic       locked;

    logic       lvl;
    int         checks;
    int         errors;
    int         valid_count;
    int         neg_cnt;
    int         last_valid_neg;
    int         last_gap;
    bit         lost_seen;

    int         cyc;
    int         last_edge_cyc;
    int         prev_len;
    int         since;
    logic       last_note;
    int         m_state;
    int         m_period;
    bit         m_valid;
    bit         model_live;

    note_detector #(
        .MAX_H(MAX_H)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .note  (note),
        .period(period),
        .valid (valid),
        .state (state),
        .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a level's length is the distance between edge timestamps; the
    // detector is locked while the last two measured lengths agree.
    initial begin
        cyc           = 0;
        last_edge_cyc = 0;
        prev_len      = 0;
        last_note     = 1'b0;
        m_state       = 0;
        m_period      = 0;
        m_valid       = 1'b0;
        model_live    = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            m_valid = 1'b0;
            if (!rst) begin
                m_state   = 0;
                m_period  = 0;
                last_note = 1'b0;
                prev_len  = 0;
            end else begin
                since = cyc - last_edge_cyc;
                if (note != last_note) begin
                    if (m_state == 0 || m_state == 3) begin
                        m_state  = 1;
                        prev_len = 0;
                    end else begin
                        if (prev_len == since) begin
                            m_state  = 2;
                            m_period = since - 1;
                            m_valid  = 1'b1;
                        end else begin
                            m_state = 1;
                        end
                        prev_len = since;
                    end
                    last_edge_cyc = cyc;
                end else if ((m_state == 1 || m_state == 2) && since == MAX_H) begin
                    m_state  = 3;
                    prev_len = 0;
                end
                last_note = note;
            end
            model_live = 1'b1;
        end
    end

    initial begin
        neg_cnt        = 0;
        last_valid_neg = 0;
        last_gap       = 0;
        forever begin
            @(negedge clk);
            if (model_live) begin
                neg_cnt++;
                checks++;
                if (state !== 2'(m_state) || period !== 8'(m_period) ||
                    valid !== m_valid || locked !== (m_state == 2)) begin
                    errors++;
                    $display("[TB] FAIL cycle %0d: state=%0d period=%0d valid=%0b locked=%0b, expected state=%0d period=%0d valid=%0b locked=%0b",
                             cyc, state, period, valid, locked, m_state, m_period, m_valid, m_state == 2);
                end
                if (valid === 1'b1) begin
                    valid_count++;
                    last_gap       = neg_cnt - last_valid_neg;
                    last_valid_neg = neg_cnt;
                end
                if (state === 2'd3) lost_seen = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input int len, input int count);
        for (int i = 0; i < count; i++) begin
            lvl  = ~lvl;
            note = lvl;
            repeat (len) @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        valid_count = 0;
        lost_seen   = 1'b0;
        rst         = 1'b0;
        note        = 1'b0;
        lvl         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_period", int'(period), 0);
        checkOutput("reset_valid", int'(valid), 0);
        checkOutput("reset_locked", int'(locked), 0);
        rst = 1'b1;

        $display("[TB] steady 6-cycle tone");
        valid_count = 0;
        applyStimulus(6, 8);
        checkOutput("tone6_locked", int'(locked), 1);
        checkOutput("tone6_period", int'(period), 5);
        checkOutput("tone6_valid_count", valid_count, 6);
        checkOutput("tone6_valid_gap", last_gap, 6);

        $display("[TB] tone change to 10-cycle levels");
        applyStimulus(10, 2);
        checkOutput("tone10_acq_state", int'(state), 1);
        checkOutput("tone10_acq_period", int'(period), 5);
        applyStimulus(10, 2);
        checkOutput("tone10_locked", int'(locked), 1);
        checkOutput("tone10_period", int'(period), 9);
        checkOutput("tone10_valid_gap", last_gap, 10);

        $display("[TB] relock at 6, then note stuck high");
        applyStimulus(6, 4);
        checkOutput("tone6b_locked", int'(locked), 1);
        lvl  = 1'b1;
        note = 1'b1;
        repeat (MAX_H) @(posedge clk);
        #1;
        checkOutput("stuck_before_timeout", int'(state), 2);
        @(posedge clk);
        #1;
        checkOutput("stuck_timeout_state", int'(state), 3);
        checkOutput("stuck_timeout_period", int'(period), 5);
        checkOutput("stuck_timeout_locked", int'(locked), 0);
        repeat (40) @(posedge clk);
        #1;
        applyStimulus(6, 2);
        checkOutput("resume_not_locked", int'(state), 1);
        applyStimulus(6, 2);
        checkOutput("resume_locked", int'(locked), 1);
        checkOutput("resume_period", int'(period), 5);

        $display("[TB] jitter 7/6");
        applyStimulus(7, 1);
        applyStimulus(6, 1);
        valid_count = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(7, 1);
            applyStimulus(6, 1);
        end
        checkOutput("jitter_valid_count", valid_count, 0);
        checkOutput("jitter_state", int'(state), 1);

        $display("[TB] 1-cycle levels");
        applyStimulus(1, 10);
        checkOutput("h1_locked", int'(locked), 1);
        checkOutput("h1_period", int'(period), 0);
        checkOutput("h1_valid", int'(valid), 1);
        checkOutput("h1_valid_gap", last_gap, 1);

        $display("[TB] 256-cycle levels");
        lost_seen = 1'b0;
        applyStimulus(256, 4);
        checkOutput("h256_locked", int'(locked), 1);
        checkOutput("h256_period", int'(period), 255);
        checkOutput("h256_no_lost", int'(lost_seen), 0);

        $display("[TB] reset mid-lock");
        applyStimulus(6, 4);
        checkOutput("prereset_locked", int'(locked), 1);
        rst  = 1'b0;
        lvl  = 1'b0;
        note = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("midreset_state", int'(state), 0);
        checkOutput("midreset_period", int'(period), 0);
        checkOutput("midreset_valid", int'(valid), 0);
        checkOutput("midreset_locked", int'(locked), 0);
        applyStimulus(6, 2);
        checkOutput("postreset_acq", int'(state), 1);
        applyStimulus(6, 1);
        checkOutput("postreset_locked", int'(locked), 1);
        checkOutput("postreset_period", int'(period), 5);

        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/note_detector.md
# note_detector

Measures the half-period of an incoming square-wave note and reports it in the same 8-bit encoding the note generator's `period` input uses. An input level held for N cycles reports `period = N-1`. The block is the receive end of the note interface: it sits downstream of a note generator or a pin, locks onto a stable tone, and flags loss of signal. It is a single-clock, synchronous design.

## Interface
Parameters:
- `MAX_H`, default 256: longest measurable half-period in cycles. This fixes the 8-bit `period` range and the timeout.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-low reset
- `note`  in  1  square-wave input, synchronous to `clk`
- `period`  out  8  last locked half-period minus 1
- `valid`  out  1  one-cycle pulse: a matching half-period was just confirmed in LOCK
- `state`  out  2  FSM state: WAIT=0, ACQ=1, LOCK=2, LOST=3
- `locked`  out  1  high when `state` is LOCK

## Operation
- `note_q` registers `note`. An edge exists in any cycle where `note != note_q`; that cycle is the first cycle of the new level.
- Interval counter `cnt` is 9 bits:
  - set to 1 on an edge;
  - otherwise incremented;
  - saturates at `MAX_H`.
- On an edge, the previous level's length is `H = cnt`, with 1 ≤ H ≤ 256.
- Internal registers: `cand` (9 bits) and flag `cand_v`.
- FSM on an edge:
  - WAIT → ACQ, `cand_v=0`. The first edge only aligns; it is never measured.
  - ACQ, `cand_v=0` → stay in ACQ; `cand=H`, `cand_v=1`.
  - ACQ, `cand_v=1`, `H==cand` → LOCK; `period=H-1`, `valid=1`.
  - ACQ, `cand_v=1`, `H!=cand` → stay in ACQ; `cand=H`.
  - LOCK, `H==cand` → stay in LOCK; `period=H-1` (same value), `valid=1`.
  - LOCK, `H!=cand` → ACQ; `cand=H`, `cand_v=1`; `period` holds; no `valid`.
  - LOST → ACQ, `cand_v=0`. The level that just ended exceeded `MAX_H` and is discarded.
- Timeout: in ACQ or LOCK, a cycle with `cnt==MAX_H` and no edge → LOST, `cand_v=0`. `period` holds its last locked value.
- In WAIT and LOST, `cnt` saturates with no further effect.
- Width rules:
  - `period = H-1` truncated to 8 bits; H=256 gives 255.
  - H=1 (note toggling every cycle) gives 0.
- Reset (`rst==0` at a clock edge, any state, including mid-lock) forces:
  - `state=WAIT`, `period=0`, `valid=0`, `locked=0`;
  - `note_q=0`, `cnt=0`, `cand=0`, `cand_v=0`.
  - If `note=1` in the first cycle after reset, that edge is the WAIT alignment edge.

## Timing
- `state`, `period`, `valid` and `locked` are registered. They update at the rising edge that ends the edge cycle, i.e. one cycle after the new level first appears on `note`.
- Lock latency from WAIT with a steady tone:
  - third edge after alignment;
  - the first edge aligns, the second sets `cand`, the third confirms.
- In LOCK, `valid` pulses exactly once per half-period, every H cycles. Never two consecutive cycles unless H=1.
- Simultaneous edge and `cnt==MAX_H`: the edge wins. H=256 is a legal measurement, not a timeout.
- Timeout fires exactly `MAX_H` cycles after the last edge cycle, with no further edge. LOST is visible one cycle later.

## Structure
- Shared package `note_pkg` holds:
  - the state encoding constants (WAIT/ACQ/LOCK/LOST);
  - the `MAX_H` constant, shared with the note generator's period width.
- One sub-module, `note_interval_counter`:
  - owns `note_q`, edge detect and the saturating 9-bit `cnt`;
  - exports `edge`, `h` (= `cnt`) and `sat` (`cnt==MAX_H`).
- The top module holds the FSM, `cand`/`cand_v` and the output registers.

## Test plan
- Steady tone, level held 6 cycles → LOCK after the third edge; `period=5`; `valid` pulses every 6 cycles; `locked=1`.
- Extremes:
  - levels held 1 cycle → `period=0`, `valid` every cycle;
  - levels held 256 cycles → `period=255` with no LOST.
- Tone change from 6-cycle to 10-cycle levels while locked:
  - first 10-cycle edge → ACQ, `period` stays 5;
  - next 10-cycle edge → LOCK, `period=9`.
- Note stuck high after LOCK at `period=5` → LOST exactly 256 cycles after the last edge; `period` holds 5. Resumed 6-cycle tone relocks after the third edge.
- Jitter, alternating 6- and 7-cycle levels → never reaches LOCK; `valid` stays 0; `state` stays ACQ.
- `rst=0` asserted for one cycle mid-LOCK → all outputs zero and WAIT the next cycle; relock requires three fresh edges.
